vend_dispense_ctrl: RTL and testbench
=====================================

VEND_DISPENSE_CTRL -- requirements
Module: vend_dispense_ctrl

Interface
REQ-001 Parameter STOCK_W, default 4: width of the bottle stock counter.
REQ-002 Parameter STOCK_MAX, default 15: stock value loaded on refill and at reset.
REQ-003 Parameter TIMEOUT_CYC, default 200: maximum MOTOR cycles before a fault is raised.
REQ-004 Parameter PULSE_CYC, default 3: coin ejector pulse width in cycles.
REQ-005 Parameter GAP_CYC, default 2: low gap between successive coin pulses in cycles.
REQ-006 clk  in  1  single clock; all state updates on its rising edge.
REQ-007 rst  in  1  asynchronous, active-low reset.
REQ-008 vend  in  1  one-cycle pulse from the vending FSM requesting one bottle.
REQ-009 change  in  2  change code: 00 none, 01 one 5rs coin, 10 two 5rs coins, 11 illegal.
REQ-010 refill  in  1  operator refill strobe.
REQ-011 motor_done  in  1  dispense motor completion, level or pulse.
REQ-012 fault_clr  in  1  operator fault acknowledge.
REQ-013 motor_on  out  1  dispense motor enable.
REQ-014 coin_pulse  out  1  5rs coin ejector drive.
REQ-015 busy  out  1  controller not idle; upstream holds off requests while high.
REQ-016 empty  out  1  stock equals zero.
REQ-017 fault  out  1  motor timeout latched.
REQ-018 stock  out  STOCK_W  current bottle count.

Function
REQ-019 States SHALL be IDLE, MOTOR, COIN_ON, COIN_GAP and FAULT; motor_on, coin_pulse, busy and fault SHALL be Moore outputs decoded from the state register.
REQ-020 In IDLE, a clock edge sampling vend=1 or change!=00 SHALL latch the request and leave IDLE on that same edge; the output asserts in the following cycle.
REQ-021 Coin count SHALL be 3 bits, loaded as 0, 1 or 2 from change; change=11 SHALL load 0.
REQ-022 A vend request while empty=1 SHALL NOT start the motor and SHALL add 2 to the coin count (10rs refund), giving a maximum count of 4.
REQ-023 Next state from the accepting edge: MOTOR if vend=1 and empty=0; otherwise COIN_ON if the coin count is greater than 0; otherwise IDLE.
REQ-024 Requests arriving while busy=1 SHALL be ignored.
REQ-025 MOTOR: motor_on=1 and a cycle timer runs; motor_done=1 SHALL decrement stock and select COIN_ON if the coin count is greater than 0, else IDLE.
REQ-026 If the timer reaches TIMEOUT_CYC-1 with motor_done=0, the block SHALL enter FAULT, leave stock unchanged and discard pending coins.
REQ-027 motor_done on the timeout cycle SHALL take priority over the timeout (success).
REQ-028 COIN_ON SHALL hold coin_pulse=1 for exactly PULSE_CYC cycles, then decrement the coin count and enter COIN_GAP.
REQ-029 COIN_GAP SHALL hold coin_pulse=0 for GAP_CYC cycles, then enter COIN_ON if the coin count is greater than 0, else IDLE.
REQ-030 FAULT SHALL hold fault=1 with all drives low until fault_clr=1, then return to IDLE; requests are ignored while in FAULT.
REQ-031 refill=1 SHALL load stock with STOCK_MAX at the next edge in any state.
REQ-032 refill SHALL win over a simultaneous motor_done decrement.
REQ-033 stock SHALL never decrement below 0.
REQ-034 empty SHALL equal (stock==0) and SHALL be decoded from the stock register.

Reset
REQ-035 rst=0 SHALL immediately force: state IDLE, motor_on=0, coin_pulse=0, busy=0, fault=0, stock=STOCK_MAX, empty=0, timers=0, coin count=0.
REQ-036 Reset asserted mid-MOTOR or mid-COIN_ON SHALL drop the drive outputs without completing the pending operation.
REQ-037 Release of rst SHALL be honoured on the first clk edge after deassertion.

Structure
REQ-038 A shared package SHALL hold the state enumeration, the change-code constants (NONE, C5, C10) and the coin-count width.
REQ-039 One sub-module, pulse_timer (a load/count-down/terminal-count timer), SHALL be used for the motor timeout, pulse and gap timing.

Verification
REQ-040 Reset, then vend=1 with change=00 and motor_done returned after 5 cycles -> motor_on high for 5 cycles, stock goes 15->14, busy drops the next cycle.
REQ-041 vend=1 with change=10 -> one motor cycle followed by exactly two coin_pulse pulses of 3 high cycles each separated by a 2-cycle gap.
REQ-042 stock forced to 0, then vend=1 with change=01 -> no motor_on and three coin pulses; empty stays 1.
REQ-043 motor_done withheld -> fault=1 after 200 MOTOR cycles with no coin pulses; fault_clr=1 returns the block to IDLE.
REQ-044 refill and motor_done coincident at stock=3 -> stock=15.
REQ-045 rst=0 during the second coin pulse -> coin_pulse drops immediately; after release the block is IDLE with busy=0.

Source files
------------

// File: rtl/vend_dispense_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : vend_dispense_ctrl_pkg
// Brief    : Shared states, change codes and coin-count helpers for the
//            bottle dispense controller.
// Revision : 1.0 - initial release
// ============================================================================
package vend_dispense_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        MOTOR    = 3'd1,
        COIN_ON  = 3'd2,
        COIN_GAP = 3'd3,
        FAULT    = 3'd4
    } state_t;

    localparam logic [1:0] c_chg_none = 2'b00;
    localparam logic [1:0] c_chg_c5   = 2'b01;
    localparam logic [1:0] c_chg_c10  = 2'b10;

    // Wide enough for two change coins plus a two-coin refund.
    localparam int c_coin_w = 3;
    typedef logic [c_coin_w-1:0] coin_t;

    // The illegal code 11 pays nothing.
    function automatic coin_t coin_load(input logic [1:0] chg);
        case (chg)
            c_chg_c5:  return coin_t'(1);
            c_chg_c10: return coin_t'(2);
            default:   return coin_t'(0);
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/vend_dispense_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : vend_dispense_ctrl_if
// Brief    : Request/status bundle between the vending FSM, operator panel
//            and the dispense controller.
// Revision : 1.0 - initial release
// ============================================================================
interface vend_dispense_ctrl_if #(
    parameter int STOCK_W = 4
) ();
    logic               vend;
    logic [1:0]         change;
    logic               refill;
    logic               motor_done;
    logic               fault_clr;
    logic               motor_on;
    logic               coin_pulse;
    logic               busy;
    logic               empty;
    logic               fault;
    logic [STOCK_W-1:0] stock;

    modport master (
        output vend, change, refill, motor_done, fault_clr,
        input  motor_on, coin_pulse, busy, empty, fault, stock
    );

    modport slave (
        input  vend, change, refill, motor_done, fault_clr,
        output motor_on, coin_pulse, busy, empty, fault, stock
    );
endinterface
`default_nettype wire

// File: rtl/vend_dispense_ctrl_pulse_timer.sv
`default_nettype none
// ============================================================================
// Module   : vend_dispense_ctrl_pulse_timer
// Brief    : Loadable count-down timer; terminal count flags the last cycle.
// Revision : 1.0 - initial release
// ============================================================================
module vend_dispense_ctrl_pulse_timer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    output logic             o_tc
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (r_count != '0) begin
            r_count <= r_count - WIDTH'(1);
        end
    end

    assign o_tc = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/vend_dispense_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : vend_dispense_ctrl
// Brief    : Bottle dispense motor and 5rs coin-return sequencer with stock
//            tracking and motor timeout fault.
// Revision : 1.0 - initial release
// ============================================================================
module vend_dispense_ctrl
    import vend_dispense_ctrl_pkg::*;
#(
    parameter int STOCK_W     = 4,
    parameter int STOCK_MAX   = 15,
    parameter int TIMEOUT_CYC = 200,
    parameter int PULSE_CYC   = 3,
    parameter int GAP_CYC     = 2
) (
    input  logic                clk,
    input  logic                rst,
    vend_dispense_ctrl_if.slave bus
);

    localparam int c_max_ab  = (TIMEOUT_CYC > PULSE_CYC) ? TIMEOUT_CYC : PULSE_CYC;
    localparam int c_tmr_max = (c_max_ab > GAP_CYC) ? c_max_ab : GAP_CYC;
    localparam int c_tmr_w   = $clog2(c_tmr_max + 1);

    // Timer is loaded with N-1 so a state lasts exactly N cycles.
    localparam logic [c_tmr_w-1:0] c_ld_motor = c_tmr_w'(TIMEOUT_CYC - 1);
    localparam logic [c_tmr_w-1:0] c_ld_pulse = c_tmr_w'(PULSE_CYC - 1);
    localparam logic [c_tmr_w-1:0] c_ld_gap   = c_tmr_w'(GAP_CYC - 1);
    localparam logic [STOCK_W-1:0] c_stock_full = STOCK_W'(STOCK_MAX);

    state_t               r_state;
    state_t               w_state_nx;
    coin_t                r_coins;
    coin_t                w_coins_nx;
    coin_t                w_req_coins;
    logic [STOCK_W-1:0]   r_stock;
    logic                 w_empty;
    logic                 w_dispense;
    logic                 w_tmr_load;
    logic [c_tmr_w-1:0]   w_tmr_val;
    logic                 w_tmr_tc;

    assign w_empty     = (r_stock == '0);
    // A vend that cannot be served is refunded as two extra coins.
    assign w_req_coins = coin_load(bus.change)
                       + ((bus.vend && w_empty) ? coin_t'(2) : coin_t'(0));

    vend_dispense_ctrl_pulse_timer #(
        .WIDTH (c_tmr_w)
    ) u_timer (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_tmr_load),
        .i_load_val (w_tmr_val),
        .o_tc       (w_tmr_tc)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_coins <= '0;
        end else begin
            r_state <= w_state_nx;
            r_coins <= w_coins_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_coins_nx = r_coins;
        w_tmr_load = 1'b0;
        w_tmr_val  = '0;
        w_dispense = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.vend || (bus.change != c_chg_none)) begin
                    w_coins_nx = w_req_coins;
                    if (bus.vend && !w_empty) begin
                        w_state_nx = MOTOR;
                        w_tmr_load = 1'b1;
                        w_tmr_val  = c_ld_motor;
                    end else if (w_req_coins != '0) begin
                        w_state_nx = COIN_ON;
                        w_tmr_load = 1'b1;
                        w_tmr_val  = c_ld_pulse;
                    end
                end
            end
            MOTOR: begin
                // Completion on the final timer cycle still counts as success.
                if (bus.motor_done) begin
                    w_dispense = 1'b1;
                    if (r_coins != '0) begin
                        w_state_nx = COIN_ON;
                        w_tmr_load = 1'b1;
                        w_tmr_val  = c_ld_pulse;
                    end else begin
                        w_state_nx = IDLE;
                    end
                end else if (w_tmr_tc) begin
                    w_state_nx = FAULT;
                    w_coins_nx = '0;
                end
            end
            COIN_ON: begin
                if (w_tmr_tc) begin
                    w_coins_nx = r_coins - coin_t'(1);
                    w_state_nx = COIN_GAP;
                    w_tmr_load = 1'b1;
                    w_tmr_val  = c_ld_gap;
                end
            end
            COIN_GAP: begin
                if (w_tmr_tc) begin
                    if (r_coins != '0) begin
                        w_state_nx = COIN_ON;
                        w_tmr_load = 1'b1;
                        w_tmr_val  = c_ld_pulse;
                    end else begin
                        w_state_nx = IDLE;
                    end
                end
            end
            FAULT: begin
                if (bus.fault_clr) begin
                    w_state_nx = IDLE;
                end
            end
            default: begin
                w_state_nx = IDLE;
                w_coins_nx = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stock <= c_stock_full;
        end else if (bus.refill) begin
            r_stock <= c_stock_full;
        end else if (w_dispense && !w_empty) begin
            r_stock <= r_stock - STOCK_W'(1);
        end
    end

    assign bus.motor_on   = (r_state == MOTOR);
    assign bus.coin_pulse = (r_state == COIN_ON);
    assign bus.busy       = (r_state != IDLE);
    assign bus.fault      = (r_state == FAULT);
    assign bus.empty      = w_empty;
    assign bus.stock      = r_stock;

endmodule
`default_nettype wire

// File: tb/tb_vend_dispense_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_vend_dispense_ctrl
// Brief    : Directed self-checking bench for vend_dispense_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vend_dispense_ctrl;
    import vend_dispense_ctrl_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_vec = 0;
    int   n_err = 0;

    logic [31:0] m_bits, c_bits, b_bits;
    int          nm, nc, nf;

    always #5 clk = ~clk;

    vend_dispense_ctrl_if #(.STOCK_W(4)) bus ();

    vend_dispense_ctrl #(
        .STOCK_W     (4),
        .STOCK_MAX   (15),
        .TIMEOUT_CYC (200),
        .PULSE_CYC   (3),
        .GAP_CYC     (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic start(input logic v, input logic [1:0] chg);
        bus.vend   = v;
        bus.change = chg;
    endtask

    // Records one bit per cycle; bit k-1 is the k-th cycle after the request edge.
    task automatic capture(input int n, input int done_at, input int noise_at,
                           output logic [31:0] m, output logic [31:0] c,
                           output logic [31:0] b);
        m = '0; c = '0; b = '0;
        for (int k = 1; k <= n; k++) begin
            @(negedge clk);
            m[k-1] = bus.motor_on;
            c[k-1] = bus.coin_pulse;
            b[k-1] = bus.busy;
            bus.vend       = (k == noise_at);
            bus.change     = (k == noise_at) ? c_chg_c10 : c_chg_none;
            bus.motor_done = (k == done_at);
        end
        bus.vend = 1'b0; bus.change = c_chg_none; bus.motor_done = 1'b0;
    endtask

    task automatic vend_one();
        logic [31:0] m, c, b;
        start(1'b1, c_chg_none);
        capture(3, 1, 0, m, c, b);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        bus.vend = 1'b0; bus.change = c_chg_none; bus.refill = 1'b0;
        bus.motor_done = 1'b0; bus.fault_clr = 1'b0;
        #1 rst = 1'b0;
        #1;
        chk("rst_motor_on", int'(bus.motor_on), 0);
        chk("rst_coin", int'(bus.coin_pulse), 0);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_fault", int'(bus.fault), 0);
        chk("rst_stock", int'(bus.stock), 15);
        chk("rst_empty", int'(bus.empty), 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;

        // Plain vend, motor completes in its 5th cycle
        start(1'b1, c_chg_none);
        capture(7, 5, 0, m_bits, c_bits, b_bits);
        chk("v0_motor", int'(m_bits), 32'h1F);
        chk("v0_coin", int'(c_bits), 0);
        chk("v0_busy", int'(b_bits), 32'h1F);
        chk("v0_stock", int'(bus.stock), 14);

        // Vend with two coins of change; a vend during the gap is ignored
        start(1'b1, c_chg_c10);
        capture(14, 2, 6, m_bits, c_bits, b_bits);
        chk("v10_motor", int'(m_bits), 32'h3);
        chk("v10_coin", int'(c_bits), 32'h39C);
        chk("v10_busy", int'(b_bits), 32'hFFF);
        chk("v10_stock", int'(bus.stock), 13);

        // Illegal change code alone pays nothing
        start(1'b0, 2'b11);
        capture(3, 0, 0, m_bits, c_bits, b_bits);
        chk("c11_busy", int'(b_bits), 0);
        chk("c11_coin", int'(c_bits), 0);

        repeat (10) vend_one();
        chk("drain3_stock", int'(bus.stock), 3);
        chk("drain3_empty", int'(bus.empty), 0);

        // Refill coincident with motor completion
        start(1'b1, c_chg_none);
        @(negedge clk);
        chk("ref_motor_on", int'(bus.motor_on), 1);
        bus.vend = 1'b0; bus.motor_done = 1'b1; bus.refill = 1'b1;
        @(negedge clk);
        bus.motor_done = 1'b0; bus.refill = 1'b0;
        chk("ref_stock", int'(bus.stock), 15);
        chk("ref_busy", int'(bus.busy), 0);

        // Motor timeout, pending coin discarded
        start(1'b1, c_chg_c5);
        nm = 0; nc = 0; nf = 0;
        for (int k = 1; k <= 200; k++) begin
            @(negedge clk);
            if (k == 1) start(1'b0, c_chg_none);
            nm += int'(bus.motor_on);
            nc += int'(bus.coin_pulse);
            nf += int'(bus.fault);
        end
        chk("to_motor_cycles", nm, 200);
        chk("to_coin_cycles", nc, 0);
        chk("to_early_fault", nf, 0);
        @(negedge clk);
        chk("to_fault", int'(bus.fault), 1);
        chk("to_motor_off", int'(bus.motor_on), 0);
        chk("to_busy", int'(bus.busy), 1);
        chk("to_stock", int'(bus.stock), 15);
        start(1'b1, c_chg_c10);
        @(negedge clk);
        start(1'b0, c_chg_none);
        repeat (2) @(negedge clk);
        chk("flt_hold", int'(bus.fault), 1);
        chk("flt_motor", int'(bus.motor_on), 0);
        chk("flt_coin", int'(bus.coin_pulse), 0);
        bus.fault_clr = 1'b1;
        @(negedge clk);
        bus.fault_clr = 1'b0;
        chk("clr_fault", int'(bus.fault), 0);
        chk("clr_busy", int'(bus.busy), 0);
        nc = 0;
        repeat (3) begin
            @(negedge clk);
            nc += int'(bus.coin_pulse) + int'(bus.busy);
        end
        chk("clr_quiet", nc, 0);

        repeat (15) vend_one();
        chk("drain0_stock", int'(bus.stock), 0);
        chk("drain0_empty", int'(bus.empty), 1);

        // Vend while empty with one coin: refund makes three pulses
        start(1'b1, c_chg_c5);
        capture(17, 0, 0, m_bits, c_bits, b_bits);
        chk("emp_motor", int'(m_bits), 0);
        chk("emp_coin", int'(c_bits), 32'h1CE7);
        chk("emp_busy", int'(b_bits), 32'h7FFF);
        chk("emp_stock", int'(bus.stock), 0);
        chk("emp_empty", int'(bus.empty), 1);

        bus.refill = 1'b1;
        @(negedge clk);
        bus.refill = 1'b0;
        chk("refill_stock", int'(bus.stock), 15);

        // Asynchronous reset during the second coin pulse
        start(1'b1, c_chg_c10);
        capture(9, 2, 0, m_bits, c_bits, b_bits);
        chk("ar_coin_pre", int'(c_bits), 32'h19C);
        chk("ar_pulse_hi", int'(bus.coin_pulse), 1);
        #1 rst = 1'b0;
        #1;
        chk("ar_coin_drop", int'(bus.coin_pulse), 0);
        chk("ar_busy_drop", int'(bus.busy), 0);
        chk("ar_stock", int'(bus.stock), 15);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("ar_rel_busy", int'(bus.busy), 0);
        chk("ar_rel_coin", int'(bus.coin_pulse), 0);
        start(1'b1, c_chg_none);
        @(negedge clk);
        start(1'b0, c_chg_none);
        chk("ar_first_edge", int'(bus.motor_on), 1);
        bus.motor_done = 1'b1;
        @(negedge clk);
        bus.motor_done = 1'b0;
        chk("ar_final_stock", int'(bus.stock), 14);
        chk("ar_final_busy", int'(bus.busy), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
